// File: rtl/sa_ctrl_if.sv
// Command/array bundle between the host, sa_ctrl and the systolic-array edge buffers.
// Perf counter outputs exist only when SA_CTRL_PERF_EN is defined.
interface sa_ctrl_if #(
  parameter int ROWS    = 4,
  parameter int MAX_VEC = 256
);
  localparam int VEC_W = $clog2(MAX_VEC + 1);
  localparam int IDX_W = $clog2(MAX_VEC);
  localparam int RW    = $clog2(ROWS);

  logic             i_start;
  logic [VEC_W-1:0] i_num_vec;
  logic             i_skip_preload;
  logic             i_abort;
  logic             o_busy;
  logic             o_done;
  logic             o_mode;
  logic             o_w_rd_en;
  logic [RW-1:0]    o_w_rd_row;
  logic             o_act_rd_en;
  logic [IDX_W-1:0] o_act_rd_idx;
  logic             o_psum_valid;
  logic [IDX_W-1:0] o_psum_idx;
`ifdef SA_CTRL_PERF_EN
  logic [31:0]      o_perf_cycles;
  logic [15:0]      o_perf_jobs;
`endif

  modport master (
    output i_start, i_num_vec, i_skip_preload, i_abort,
    input  o_busy, o_done, o_mode, o_w_rd_en, o_w_rd_row,
           o_act_rd_en, o_act_rd_idx, o_psum_valid, o_psum_idx
`ifdef SA_CTRL_PERF_EN
    , input o_perf_cycles, o_perf_jobs
`endif
  );

  modport slave (
    input  i_start, i_num_vec, i_skip_preload, i_abort,
    output o_busy, o_done, o_mode, o_w_rd_en, o_w_rd_row,
           o_act_rd_en, o_act_rd_idx, o_psum_valid, o_psum_idx
`ifdef SA_CTRL_PERF_EN
    , output o_perf_cycles, o_perf_jobs
`endif
  );
endinterface

// File: rtl/sa_ctrl.sv
// Job sequencer for the ROWSxCOLS systolic array: weight preload, activation streaming, psum tagging.
// Define SA_CTRL_PERF_EN to add the busy-cycle and completed-job counters.
module sa_ctrl #(
  parameter int ROWS    = 4,
  parameter int COLS    = 4,
  parameter int MAX_VEC = 256
) (
  input  logic      clk,
  input  logic      rst_n,
  sa_ctrl_if.slave  bus
);
  localparam int VEC_W    = $clog2(MAX_VEC + 1);
  localparam int IDX_W    = $clog2(MAX_VEC);
  localparam int RW       = $clog2(ROWS);
  localparam int PIPE_LAT = ROWS + COLS;
  localparam int CNT_W    = (VEC_W > RW + 1) ? VEC_W : RW + 1;

  typedef enum logic [2:0] {S_IDLE, S_PRELOAD, S_COMPUTE, S_DRAIN, S_DONE} state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [VEC_W-1:0] num_vec_q, num_vec_d;
  logic             w_valid_q, w_valid_d;
  logic             flush;
  logic             busy_q, busy_d, done_q, done_d, mode_q, mode_d;
  logic             w_rd_en_q, w_rd_en_d, act_rd_en_q, act_rd_en_d;
  logic [RW-1:0]    w_rd_row_q, w_rd_row_d;
  logic [IDX_W-1:0] act_rd_idx_q, act_rd_idx_d;
  logic [PIPE_LAT-1:0] pipe_vld_q, pipe_vld_d;
  logic [IDX_W-1:0]    pipe_idx_q [PIPE_LAT];
  logic [IDX_W-1:0]    pipe_idx_d [PIPE_LAT];

  function automatic logic [VEC_W-1:0] clamp_vec(input logic [VEC_W-1:0] n);
    return (n > VEC_W'(MAX_VEC)) ? VEC_W'(MAX_VEC) : n;
  endfunction

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    num_vec_d = num_vec_q;
    w_valid_d = w_valid_q;
    flush     = 1'b0;
    unique case (state_q)
      S_IDLE: if (bus.i_start) begin
        num_vec_d = clamp_vec(bus.i_num_vec);
        cnt_d     = '0;
        if (bus.i_skip_preload && w_valid_q)
          state_d = (num_vec_d == '0) ? S_DONE : S_COMPUTE;
        else
          state_d = S_PRELOAD;
      end
      S_PRELOAD: if (cnt_q == CNT_W'(ROWS)) begin
        w_valid_d = 1'b1;
        cnt_d     = '0;
        state_d   = (num_vec_q == '0) ? S_DONE : S_COMPUTE;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      S_COMPUTE: if (cnt_q == CNT_W'(num_vec_q) - CNT_W'(1)) begin
        cnt_d   = '0;
        state_d = S_DRAIN;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
      // Only the final tag remains in flight: this is its output cycle.
      S_DRAIN: if (pipe_vld_q == {1'b1, {(PIPE_LAT-1){1'b0}}}) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
    if (bus.i_abort && state_q != S_IDLE) begin
      state_d = S_IDLE;
      cnt_d   = '0;
      flush   = 1'b1;
      if (state_q == S_PRELOAD) w_valid_d = 1'b0;
    end

    // Outputs are registered, so they are decoded from the next state.
    busy_d       = (state_d == S_PRELOAD) || (state_d == S_COMPUTE) || (state_d == S_DRAIN);
    done_d       = (state_d == S_DONE);
    w_rd_en_d    = (state_d == S_PRELOAD) && (cnt_d < CNT_W'(ROWS));
    w_rd_row_d   = w_rd_en_d ? RW'(ROWS - 1) - cnt_d[RW-1:0] : '0;
    mode_d       = !((state_d == S_PRELOAD) && (cnt_d != '0));
    act_rd_en_d  = (state_d == S_COMPUTE);
    act_rd_idx_d = act_rd_en_d ? cnt_d[IDX_W-1:0] : '0;

    pipe_vld_d    = flush ? '0 : {pipe_vld_q[PIPE_LAT-2:0], act_rd_en_q};
    pipe_idx_d[0] = act_rd_idx_q;
    for (int i = 1; i < PIPE_LAT; i++) pipe_idx_d[i] = pipe_idx_q[i-1];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      num_vec_q    <= '0;
      w_valid_q    <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      mode_q       <= 1'b1;
      w_rd_en_q    <= 1'b0;
      w_rd_row_q   <= '0;
      act_rd_en_q  <= 1'b0;
      act_rd_idx_q <= '0;
      pipe_vld_q   <= '0;
      for (int i = 0; i < PIPE_LAT; i++) pipe_idx_q[i] <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      num_vec_q    <= num_vec_d;
      w_valid_q    <= w_valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      mode_q       <= mode_d;
      w_rd_en_q    <= w_rd_en_d;
      w_rd_row_q   <= w_rd_row_d;
      act_rd_en_q  <= act_rd_en_d;
      act_rd_idx_q <= act_rd_idx_d;
      pipe_vld_q   <= pipe_vld_d;
      for (int i = 0; i < PIPE_LAT; i++) pipe_idx_q[i] <= pipe_idx_d[i];
    end
  end

  assign bus.o_busy       = busy_q;
  assign bus.o_done       = done_q;
  assign bus.o_mode       = mode_q;
  assign bus.o_w_rd_en    = w_rd_en_q;
  assign bus.o_w_rd_row   = w_rd_row_q;
  assign bus.o_act_rd_en  = act_rd_en_q;
  assign bus.o_act_rd_idx = act_rd_idx_q;
  assign bus.o_psum_valid = pipe_vld_q[PIPE_LAT-1];
  assign bus.o_psum_idx   = pipe_idx_q[PIPE_LAT-1];

`ifdef SA_CTRL_PERF_EN
  logic [31:0] perf_cycles_q, perf_cycles_d;
  logic [15:0] perf_jobs_q, perf_jobs_d;

  always_comb begin
    perf_cycles_d = perf_cycles_q;
    if (busy_q && perf_cycles_q != '1) perf_cycles_d = perf_cycles_q + 32'd1;
    perf_jobs_d = perf_jobs_q + {15'd0, done_q};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_cycles_q <= '0;
      perf_jobs_q   <= '0;
    end else begin
      perf_cycles_q <= perf_cycles_d;
      perf_jobs_q   <= perf_jobs_d;
    end
  end

  assign bus.o_perf_cycles = perf_cycles_q;
  assign bus.o_perf_jobs   = perf_jobs_q;
`endif
endmodule
